imem_dmem_arbiter: RTL

- Arbitrates one single-port, variable-latency memory between two requesters: the instruction-fetch stage and the MEM-stage load/store unit.
- Generates the fetch stall and fetch-valid signals the IF stage uses to hold the PC and insert bubbles.
- Supports fetch cancellation when a jump redirects the PC, so a stale instruction never enters the pipeline.

---
 rtl/imem_dmem_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and the
// load/store unit; produces fetch stall/valid and supports cancelling an in-flight fetch.
module imem_dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // Instruction fetch side
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              control_j_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic              if_done_o,
  output logic              if_stall_o,
  // Load/store side
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  input  logic [3:0]        dm_wstrb_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_done_o,
  // Memory side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i
);

  typedef enum logic [1:0] {StIdle, StFetch, StData, StResp} state_e;

  localparam logic [3:0] MaxRun = 4'(MAX_DATA_RUN);

  state_e            state_q, state_d;
  logic [3:0]        run_q, run_d;
  logic              cancel_q, cancel_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;

  // Byte offsets are dropped: the memory is word addressed and misalignment is not trapped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[1:0], dm_addr_i[1:0]};

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    cancel_d    = cancel_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!if_req_i) begin
          run_d = '0;
        end
        // Data wins unless it has already taken MaxRun grants while a fetch was waiting.
        // With no fetch pending this branch also covers the saturated-run case.
        if (dm_req_i && (!if_req_i || (run_q < MaxRun))) begin
          state_d     = StData;
          if (if_req_i) begin
            run_d = run_q + 4'd1;
          end
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = {dm_addr_i[ADDR_W-1:2], 2'b00};
          mem_wdata_d = dm_wdata_i;
          mem_wstrb_d = dm_we_i ? dm_wstrb_i : 4'b0000;
        end else if (if_req_i) begin
          state_d     = StFetch;
          run_d       = '0;
          cancel_d    = control_j_i;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr_i[ADDR_W-1:2], 2'b00};
          mem_wdata_d = '0;
          mem_wstrb_d = 4'b0000;
        end
      end

      StFetch: begin
        if (control_j_i) begin
          cancel_d = 1'b1;
        end
        if (mem_ready_i) begin
          state_d     = StResp;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          if_done_d   = 1'b1;
          // A redirect in the completing cycle still kills the instruction.
          if (!(cancel_q || control_j_i)) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end
      end

      StData: begin
        if (mem_ready_i) begin
          state_d     = StResp;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          dm_done_d   = 1'b1;
          dm_rdata_d  = mem_rdata_i;
        end
      end

      StResp: begin
        state_d  = StIdle;
        cancel_d = 1'b0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      run_q       <= '0;
      cancel_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      cancel_q    <= cancel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign if_done_o   = if_done_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_done_o   = dm_done_q;
  assign if_stall_o  = if_req_i & ~if_valid_q;

endmodule
